// File: rtl/core_c2_biu_port.sv
`default_nettype none
// ============================================================================
//  Module   : core_c2_biu_port
//  Desc     : Single-master system-bus port for the C2 core. Converts a
//             core request/response interface into split sb_* read/write
//             channels with byte-lane strobes, load lane extraction and
//             misaligned-access detection.
//  Revision : 1.0 - initial release
// ============================================================================
module core_c2_biu_port #(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int MAX_OUT = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    // core side
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [AW-1:0]     req_addr,
    input  logic [DW-1:0]     req_wdata,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    output logic              pause,
    output logic              rd_valid,
    output logic [DW-1:0]     rd_data,
    output logic              rd_err,
    output logic              wr_done,
    output logic              wr_err,
    // read address channel
    output logic              sb_arvalid,
    input  logic              sb_arready,
    output logic [AW-1:0]     sb_araddr,
    // read data channel
    input  logic              sb_rvalid,
    output logic              sb_rready,
    input  logic [DW-1:0]     sb_rdata,
    // write channel
    output logic              sb_wvalid,
    input  logic              sb_wready,
    output logic [AW-1:0]     sb_waddr,
    output logic [DW-1:0]     sb_wdata,
    output logic [DW/8-1:0]   sb_wstrb,
    // write response channel
    input  logic              sb_bvalid,
    output logic              sb_bready,
    input  logic              sb_bresp
);

    localparam int OB = $clog2(DW/8);
    localparam int SB = DW/8;
    localparam int CW = $clog2(MAX_OUT+1);
    localparam int PW = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;
    localparam int FW = OB + 3;

    localparam logic [CW-1:0] c_max      = CW'(MAX_OUT);
    localparam logic [PW-1:0] c_last     = PW'(MAX_OUT-1);
    localparam bit            c_has_dword = (DW == 64);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic              r_ar_valid;
    logic [AW-1:0]     r_araddr;
    logic [CW-1:0]     r_rd_cnt;
    logic [PW-1:0]     r_wptr;
    logic [PW-1:0]     r_rptr;
    logic [FW-1:0]     r_fifo [MAX_OUT];

    logic              r_w_valid;
    logic [AW-1:0]     r_waddr;
    logic [DW-1:0]     r_wdata;
    logic [SB-1:0]     r_wstrb;
    logic [CW-1:0]     r_wr_cnt;

    logic              r_rd_valid;
    logic              r_rd_err;
    logic [DW-1:0]     r_rd_data;
    logic              r_wr_done;
    logic              r_wr_err;

    // ------------------------------------------------------------------
    // Combinational decode
    // ------------------------------------------------------------------
    logic              w_aligned;
    logic [AW-1:0]     w_bus_addr;
    logic [SB-1:0]     w_strb_base;
    logic [SB-1:0]     w_strb;
    logic [DW-1:0]     w_wdata_rep;

    logic              w_ar_hs, w_r_cpl, w_rd_idle, w_rd_room, w_rd_ok;
    logic              w_rd_acc, w_rd_mis;
    logic              w_w_hs, w_b_cpl, w_wr_idle, w_wr_room, w_wr_ok;
    logic              w_wr_acc, w_wr_mis;

    logic [FW-1:0]     w_fifo_in;
    logic [FW-1:0]     w_fifo_out;
    logic [OB-1:0]     w_rd_off;
    logic [1:0]        w_rd_size;
    logic              w_rd_uns;
    logic [DW-1:0]     w_shift;
    logic [DW-1:0]     w_mask;
    logic              w_sign;
    logic [DW-1:0]     w_ext;

    assign w_bus_addr = {req_addr[AW-1:OB], {OB{1'b0}}};
    assign w_fifo_in  = {req_addr[OB-1:0], req_size, req_unsigned};

    // Natural alignment check; dword only exists on a 64-bit bus
    always_comb begin
        w_aligned = 1'b0;
        case (req_size)
            2'd0:    w_aligned = 1'b1;
            2'd1:    w_aligned = ~req_addr[0];
            2'd2:    w_aligned = (req_addr[1:0] == 2'b00);
            default: w_aligned = c_has_dword && (req_addr[2:0] == 3'b000);
        endcase
    end

    // Store lane strobes and data replication across the bus
    always_comb begin
        w_strb_base = '1;
        w_wdata_rep = req_wdata;
        case (req_size)
            2'd0: begin
                w_strb_base = SB'(1);
                w_wdata_rep = {SB{req_wdata[7:0]}};
            end
            2'd1: begin
                w_strb_base = SB'(3);
                w_wdata_rep = {(DW/16){req_wdata[15:0]}};
            end
            2'd2: begin
                w_strb_base = SB'(4'hF);
                w_wdata_rep = {(DW/32){req_wdata[31:0]}};
            end
            default: begin
                w_strb_base = '1;
                w_wdata_rep = req_wdata;
            end
        endcase
    end
    assign w_strb = w_strb_base << req_addr[OB-1:0];

    // Read channel handshake and accept rules
    assign w_ar_hs   = r_ar_valid & sb_arready;
    assign w_r_cpl   = sb_rvalid & (r_rd_cnt != '0);
    assign w_rd_idle = ~r_ar_valid & (r_rd_cnt == '0);
    assign w_rd_room = (~r_ar_valid | sb_arready) & ((r_rd_cnt < c_max) | sb_rvalid);
    assign w_rd_ok   = w_aligned ? w_rd_room : w_rd_idle;
    assign w_rd_acc  = req_valid & ~req_write & w_rd_ok & w_aligned;
    assign w_rd_mis  = req_valid & ~req_write & w_rd_ok & ~w_aligned;

    // Write channel handshake and accept rules
    assign w_w_hs    = r_w_valid & sb_wready;
    assign w_b_cpl   = sb_bvalid & (r_wr_cnt != '0);
    assign w_wr_idle = ~r_w_valid & (r_wr_cnt == '0);
    assign w_wr_room = (~r_w_valid | sb_wready) & ((r_wr_cnt < c_max) | sb_bvalid);
    assign w_wr_ok   = w_aligned ? w_wr_room : w_wr_idle;
    assign w_wr_acc  = req_valid & req_write & w_wr_ok & w_aligned;
    assign w_wr_mis  = req_valid & req_write & w_wr_ok & ~w_aligned;

    assign req_ready = req_write ? w_wr_ok : w_rd_ok;
    assign pause     = req_valid & ~req_ready;

    // Load lane extraction using the oldest read-info entry
    assign w_fifo_out = r_fifo[r_rptr];
    assign w_rd_off   = w_fifo_out[FW-1:3];
    assign w_rd_size  = w_fifo_out[2:1];
    assign w_rd_uns   = w_fifo_out[0];
    assign w_shift    = sb_rdata >> {w_rd_off, 3'b000};

    // Size mask and sign bit for the extracted lane
    always_comb begin
        w_mask = '1;
        w_sign = w_shift[DW-1];
        case (w_rd_size)
            2'd0: begin w_mask = DW'(8'hFF);         w_sign = w_shift[7];  end
            2'd1: begin w_mask = DW'(16'hFFFF);      w_sign = w_shift[15]; end
            2'd2: begin w_mask = DW'(32'hFFFF_FFFF); w_sign = w_shift[31]; end
            default: begin w_mask = '1;              w_sign = w_shift[DW-1]; end
        endcase
    end
    assign w_ext = (w_shift & w_mask) | ({DW{w_sign & ~w_rd_uns}} & ~w_mask);

    // ------------------------------------------------------------------
    // Read channel: address hold register, inflight counter, FIFO pointers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ar_valid <= 1'b0;
            r_araddr   <= '0;
            r_rd_cnt   <= '0;
            r_wptr     <= '0;
            r_rptr     <= '0;
        end else begin
            if (w_rd_acc) begin
                r_ar_valid <= 1'b1;
                r_araddr   <= w_bus_addr;
                r_wptr     <= (r_wptr == c_last) ? '0 : r_wptr + 1'b1;
            end else if (w_ar_hs) begin
                r_ar_valid <= 1'b0;
            end
            if (w_r_cpl)
                r_rptr <= (r_rptr == c_last) ? '0 : r_rptr + 1'b1;
            if (w_rd_acc && !w_r_cpl)
                r_rd_cnt <= r_rd_cnt + 1'b1;
            else if (!w_rd_acc && w_r_cpl)
                r_rd_cnt <= r_rd_cnt - 1'b1;
        end
    end

    // Read-info storage; contents are only meaningful below the inflight count
    always_ff @(posedge clk) begin
        if (w_rd_acc)
            r_fifo[r_wptr] <= w_fifo_in;
    end

    // ------------------------------------------------------------------
    // Write channel: hold register and inflight counter
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_w_valid <= 1'b0;
            r_waddr   <= '0;
            r_wdata   <= '0;
            r_wstrb   <= '0;
            r_wr_cnt  <= '0;
        end else begin
            if (w_wr_acc) begin
                r_w_valid <= 1'b1;
                r_waddr   <= w_bus_addr;
                r_wdata   <= w_wdata_rep;
                r_wstrb   <= w_strb;
            end else if (w_w_hs) begin
                r_w_valid <= 1'b0;
            end
            if (w_wr_acc && !w_b_cpl)
                r_wr_cnt <= r_wr_cnt + 1'b1;
            else if (!w_wr_acc && w_b_cpl)
                r_wr_cnt <= r_wr_cnt - 1'b1;
        end
    end

    // Completion pulses, one cycle after the bus response or misaligned accept
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_valid <= 1'b0;
            r_rd_err   <= 1'b0;
            r_rd_data  <= '0;
            r_wr_done  <= 1'b0;
            r_wr_err   <= 1'b0;
        end else begin
            r_rd_valid <= w_r_cpl | w_rd_mis;
            r_rd_err   <= w_rd_mis;
            r_rd_data  <= w_r_cpl ? w_ext : '0;
            r_wr_done  <= w_b_cpl | w_wr_mis;
            r_wr_err   <= w_wr_mis | (w_b_cpl & sb_bresp);
        end
    end

    assign sb_arvalid = r_ar_valid;
    assign sb_araddr  = r_araddr;
    assign sb_rready  = 1'b1;
    assign sb_wvalid  = r_w_valid;
    assign sb_waddr   = r_waddr;
    assign sb_wdata   = r_wdata;
    assign sb_wstrb   = r_wstrb;
    assign sb_bready  = 1'b1;

    assign rd_valid   = r_rd_valid;
    assign rd_err     = r_rd_err;
    assign rd_data    = r_rd_data;
    assign wr_done    = r_wr_done;
    assign wr_err     = r_wr_err;

endmodule
`default_nettype wire

// File: tb/tb_core_c2_biu_port.sv
`default_nettype none
// ============================================================================
//  Module   : tb_core_c2_biu_port
//  Desc     : Directed self-checking bench for core_c2_biu_port, with a
//             32-bit and a 64-bit data-width instance.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_core_c2_biu_port;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;

    // 32-bit instance
    logic        req_valid, req_ready, req_write, req_unsigned, pause;
    logic [31:0] req_addr, req_wdata, rd_data;
    logic [1:0]  req_size;
    logic        rd_valid, rd_err, wr_done, wr_err;
    logic        sb_arvalid, sb_arready, sb_rvalid, sb_rready;
    logic        sb_wvalid, sb_wready, sb_bvalid, sb_bready, sb_bresp;
    logic [31:0] sb_araddr, sb_rdata, sb_waddr, sb_wdata;
    logic [3:0]  sb_wstrb;

    // 64-bit instance
    logic        d_req_valid, d_req_ready, d_req_write, d_req_unsigned, d_pause;
    logic [31:0] d_req_addr;
    logic [63:0] d_req_wdata, d_rd_data;
    logic [1:0]  d_req_size;
    logic        d_rd_valid, d_rd_err, d_wr_done, d_wr_err;
    logic        d_sb_arvalid, d_sb_arready, d_sb_rvalid, d_sb_rready;
    logic        d_sb_wvalid, d_sb_wready, d_sb_bvalid, d_sb_bready, d_sb_bresp;
    logic [31:0] d_sb_araddr, d_sb_waddr;
    logic [63:0] d_sb_rdata, d_sb_wdata;
    logic [7:0]  d_sb_wstrb;

    int checks = 0;
    int errors = 0;

    core_c2_biu_port #(.AW(32), .DW(32), .MAX_OUT(2)) u_dut32 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_size(req_size),
        .req_unsigned(req_unsigned), .pause(pause),
        .rd_valid(rd_valid), .rd_data(rd_data), .rd_err(rd_err),
        .wr_done(wr_done), .wr_err(wr_err),
        .sb_arvalid(sb_arvalid), .sb_arready(sb_arready), .sb_araddr(sb_araddr),
        .sb_rvalid(sb_rvalid), .sb_rready(sb_rready), .sb_rdata(sb_rdata),
        .sb_wvalid(sb_wvalid), .sb_wready(sb_wready), .sb_waddr(sb_waddr),
        .sb_wdata(sb_wdata), .sb_wstrb(sb_wstrb),
        .sb_bvalid(sb_bvalid), .sb_bready(sb_bready), .sb_bresp(sb_bresp)
    );

    core_c2_biu_port #(.AW(32), .DW(64), .MAX_OUT(2)) u_dut64 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(d_req_valid), .req_ready(d_req_ready), .req_write(d_req_write),
        .req_addr(d_req_addr), .req_wdata(d_req_wdata), .req_size(d_req_size),
        .req_unsigned(d_req_unsigned), .pause(d_pause),
        .rd_valid(d_rd_valid), .rd_data(d_rd_data), .rd_err(d_rd_err),
        .wr_done(d_wr_done), .wr_err(d_wr_err),
        .sb_arvalid(d_sb_arvalid), .sb_arready(d_sb_arready), .sb_araddr(d_sb_araddr),
        .sb_rvalid(d_sb_rvalid), .sb_rready(d_sb_rready), .sb_rdata(d_sb_rdata),
        .sb_wvalid(d_sb_wvalid), .sb_wready(d_sb_wready), .sb_waddr(d_sb_waddr),
        .sb_wdata(d_sb_wdata), .sb_wstrb(d_sb_wstrb),
        .sb_bvalid(d_sb_bvalid), .sb_bready(d_sb_bready), .sb_bresp(d_sb_bresp)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic rd_req(input logic [31:0] a, input logic [1:0] sz, input logic u);
        req_valid = 1'b1; req_write = 1'b0; req_addr = a; req_size = sz; req_unsigned = u;
    endtask

    initial begin
        rst_n = 1'b0;
        req_valid = 0; req_write = 0; req_addr = 0; req_wdata = 0; req_size = 0; req_unsigned = 0;
        sb_arready = 1; sb_rvalid = 0; sb_rdata = 0; sb_wready = 1; sb_bvalid = 0; sb_bresp = 0;
        d_req_valid = 0; d_req_write = 0; d_req_addr = 0; d_req_wdata = 0; d_req_size = 0;
        d_req_unsigned = 0;
        d_sb_arready = 1; d_sb_rvalid = 0; d_sb_rdata = 0; d_sb_wready = 1; d_sb_bvalid = 0;
        d_sb_bresp = 0;
        step(); step();

        // ---------------- reset state ----------------
        chk("rst_req_ready", req_ready, 1);
        chk("rst_arvalid", sb_arvalid, 0);
        chk("rst_araddr", sb_araddr, 0);
        chk("rst_wvalid", sb_wvalid, 0);
        chk("rst_wstrb", sb_wstrb, 0);
        chk("rst_rd_valid", rd_valid, 0);
        chk("rst_rd_data", rd_data, 0);
        chk("rst_rready", sb_rready, 1);
        rst_n = 1'b1;
        step();

        // ---------------- signed byte load at 0x103 ----------------
        rd_req(32'h103, 2'd0, 1'b0);
        #1 chk("ldb_ready", req_ready, 1);
        step();                                  // T
        req_valid = 0;
        chk("ldb_arvalid", sb_arvalid, 1);       // T+1
        chk("ldb_araddr", sb_araddr, 32'h100);
        step();
        chk("ldb_arvalid_clr", sb_arvalid, 0);   // T+2
        sb_rvalid = 1; sb_rdata = 32'h80FF_0000;
        chk("ldb_no_early", rd_valid, 0);
        step();
        sb_rvalid = 0;
        chk("ldb_rd_valid", rd_valid, 1);        // T+3
        chk("ldb_rd_data", rd_data, 32'hFFFF_FF80);
        chk("ldb_rd_err", rd_err, 0);
        step();
        chk("ldb_pulse_one", rd_valid, 0);

        // ---------------- half store at 0x202, bresp error ----------------
        req_valid = 1; req_write = 1; req_addr = 32'h202; req_size = 2'd1; req_wdata = 32'h1234;
        step();
        req_valid = 0;
        chk("sth_wvalid", sb_wvalid, 1);
        chk("sth_waddr", sb_waddr, 32'h200);
        chk("sth_wstrb", sb_wstrb, 4'b1100);
        chk("sth_wdata", sb_wdata, 32'h1234_1234);
        step();
        sb_bvalid = 1; sb_bresp = 1;
        step();
        sb_bvalid = 0; sb_bresp = 0;
        chk("sth_wr_done", wr_done, 1);
        chk("sth_wr_err", wr_err, 1);

        // ---------------- byte store at 0x7, good response ----------------
        req_valid = 1; req_write = 1; req_addr = 32'h7; req_size = 2'd0; req_wdata = 32'h55AB;
        step();
        req_valid = 0;
        chk("stb_wstrb", sb_wstrb, 4'b1000);
        chk("stb_wdata", sb_wdata, 32'hABAB_ABAB);
        step();
        sb_bvalid = 1;
        step();
        sb_bvalid = 0;
        chk("stb_wr_done", wr_done, 1);
        chk("stb_wr_err", wr_err, 0);
        step();

        // ---------------- MAX_OUT backpressure ----------------
        rd_req(32'h10, 2'd2, 1'b0);
        step();
        rd_req(32'h14, 2'd2, 1'b0);
        #1 chk("mo_second_ready", req_ready, 1);
        step();
        rd_req(32'h18, 2'd2, 1'b0);
        #1 chk("mo_third_ready", req_ready, 0);
        chk("mo_pause", pause, 1);
        sb_rvalid = 1; sb_rdata = 32'hCAFE_BABE;
        #1 chk("mo_ready_on_rvalid", req_ready, 1);
        step();
        sb_rvalid = 0; req_valid = 0;
        chk("mo_rd_valid", rd_valid, 1);
        chk("mo_rd_data", rd_data, 32'hCAFE_BABE);
        chk("mo_araddr_third", sb_araddr, 32'h18);
        step();
        sb_rvalid = 1; sb_rdata = 32'h1111_1111;
        step();
        sb_rvalid = 0;
        chk("mo_rd2_data", rd_data, 32'h1111_1111);
        sb_rvalid = 1; sb_rdata = 32'h2222_2222;
        step();
        sb_rvalid = 0;
        chk("mo_rd3_data", rd_data, 32'h2222_2222);
        step();

        // ---------------- arready stalled for 5 cycles ----------------
        sb_arready = 0;
        rd_req(32'h40, 2'd2, 1'b0);
        step();
        rd_req(32'h44, 2'd2, 1'b0);
        for (int i = 0; i < 5; i++) begin
            chk("stall_arvalid", sb_arvalid, 1);
            chk("stall_araddr", sb_araddr, 32'h40);
            chk("stall_ready", req_ready, 0);
            step();
        end
        sb_arready = 1;
        #1 chk("stall_ready_release", req_ready, 1);
        step();
        req_valid = 0;
        chk("stall_araddr2", sb_araddr, 32'h44);
        chk("stall_arvalid2", sb_arvalid, 1);
        step();
        sb_rvalid = 1; sb_rdata = 32'hAAAA_0001;
        step();
        sb_rdata = 32'hBBBB_0002;
        chk("stall_rd1", rd_data, 32'hAAAA_0001);
        step();
        sb_rvalid = 0;
        chk("stall_rd2", rd_data, 32'hBBBB_0002);
        step();

        // ---------------- misaligned loads ----------------
        rd_req(32'h101, 2'd2, 1'b0);
        #1 chk("mis_idle_ready", req_ready, 1);
        step();
        req_valid = 0;
        chk("mis_rd_valid", rd_valid, 1);
        chk("mis_rd_err", rd_err, 1);
        chk("mis_rd_data", rd_data, 0);
        chk("mis_no_arvalid", sb_arvalid, 0);
        rd_req(32'h20, 2'd2, 1'b0);
        step();
        rd_req(32'h101, 2'd2, 1'b0);
        #1 chk("mis_busy_hold", req_ready, 0);
        step();
        chk("mis_busy_infl", req_ready, 0);
        sb_rvalid = 1; sb_rdata = 32'h5555_AAAA;
        #1 chk("mis_busy_cpl", req_ready, 0);
        step();
        sb_rvalid = 0;
        chk("mis_prior_done", rd_valid, 1);
        chk("mis_prior_err", rd_err, 0);
        chk("mis_ready_idle", req_ready, 1);
        step();
        req_valid = 0;
        chk("mis2_rd_valid", rd_valid, 1);
        chk("mis2_rd_err", rd_err, 1);
        step();
        chk("mis2_pulse_one", rd_valid, 0);

        // dword request on a 32-bit bus is always misaligned
        rd_req(32'h10, 2'd3, 1'b0);
        step();
        req_valid = 0;
        chk("dw32_rd_err", rd_err, 1);
        chk("dw32_no_arvalid", sb_arvalid, 0);
        step();

        // ---------------- 64-bit: dword load ----------------
        d_req_valid = 1; d_req_write = 0; d_req_addr = 32'h8; d_req_size = 2'd3; d_req_unsigned = 0;
        #1 chk("d_ready", d_req_ready, 1);
        step();
        d_req_valid = 0;
        chk("d_araddr", d_sb_araddr, 32'h8);
        chk("d_arvalid", d_sb_arvalid, 1);
        step();
        d_sb_rvalid = 1; d_sb_rdata = 64'h0123_4567_89AB_CDEF;
        step();
        d_sb_rvalid = 0;
        chk("d_rd_valid", d_rd_valid, 1);
        chk("d_rd_data", d_rd_data, 64'h0123_4567_89AB_CDEF);

        // ---------------- 64-bit: reset with two reads in flight ----------------
        d_req_valid = 1; d_req_addr = 32'h20; d_req_size = 2'd2;
        step();
        d_req_addr = 32'h24;
        step();
        d_req_valid = 0;
        chk("d_pre_rst_arvalid", d_sb_arvalid, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("d_rst_arvalid", d_sb_arvalid, 0);
        chk("d_rst_araddr", d_sb_araddr, 0);
        chk("d_rst_ready", d_req_ready, 1);
        chk("d_rst_rd_valid", d_rd_valid, 0);
        chk("d_rst_rd_data", d_rd_data, 0);
        step();
        rst_n = 1'b1;
        d_sb_rvalid = 1; d_sb_rdata = 64'hFFFF_0000_FFFF_0000;
        step();
        d_sb_rvalid = 0;
        chk("d_no_stale_cpl", d_rd_valid, 0);
        step();
        chk("d_no_stale_cpl2", d_rd_valid, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/core_c2_biu_port.md
# core_c2_biu_port

Parametrised single-master system-bus port for the C2 core, one instance per master (IFU, LSU). Converts a core-side request/response interface into the sb_* split read/write channel protocol. Supports up to MAX_OUT outstanding transactions per channel, in-order completion, and sub-word alignment: byte-lane strobes on stores, sign/zero-extended lane extraction on loads. It also detects misaligned accesses.

## Interface
- AW, 32: address width, >= 8.
- DW, 32: data width, 32 or 64; OB = log2(DW/8) address offset bits.
- MAX_OUT, 2: max outstanding transactions per channel, 1..8; sizes counters and the read-info FIFO.
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- req_valid  in  1  request valid.
- req_ready  out  1  request accepted when req_valid & req_ready.
- req_write  in  1  1 = store, 0 = load.
- req_addr  in  AW  byte address.
- req_wdata  in  DW  store data, LSB-justified.
- req_size  in  2  0 = byte, 1 = half, 2 = word, 3 = dword (DW=64 only).
- req_unsigned  in  1  load zero-extends when 1.
- pause  out  1  req_valid & ~req_ready.
- rd_valid  out  1  one-cycle load completion pulse.
- rd_data  out  DW  extracted and extended load data.
- rd_err  out  1  load misaligned.
- wr_done  out  1  one-cycle store completion pulse.
- wr_err  out  1  store misaligned or sb_bresp = 1.
- sb_arvalid / sb_arready / sb_araddr[AW]: read address channel (out/in/out).
- sb_rvalid / sb_rready / sb_rdata[DW]: read data channel (in/out/in).
- sb_wvalid / sb_wready / sb_waddr[AW] / sb_wdata[DW] / sb_wstrb[DW/8]: write channel (out/in/out/out/out).
- sb_bvalid / sb_bready / sb_bresp: write response channel (in/out/in).

## Operation
- Each channel has a holding register: valid bit, address, data and strobe for writes.
- Each channel has an inflight counter, range 0..MAX_OUT.
- The read channel also has a read-info FIFO of depth MAX_OUT holding {offset[OB-1:0], size, unsigned}.
- sb_araddr and sb_waddr carry req_addr with the low OB bits cleared.
- Sb outputs are driven from the holding registers only; there is no combinational path from req_* to sb_*.
- Aligned when req_addr mod 2^size == 0. size 3 with DW=32 counts as misaligned.
- Aligned read accept requires (!ar_hold | sb_arready) & (rd_inflight < MAX_OUT | sb_rvalid).
  - On accept: load the hold register, push the FIFO, increment inflight.
- Aligned write accept uses the same rule with the w hold, wr_inflight and sb_bvalid.
  - sb_wstrb = ((1<<2^size)-1) << offset.
  - sb_wdata = req_wdata lane replicated across DW.
- Misaligned request: ready only when that channel is idle (hold empty, inflight 0).
  - No bus traffic.
  - rd_valid & rd_err (rd_data = 0) or wr_done & wr_err is asserted the next cycle.
- Hold register clears on the sb_*valid & sb_*ready handshake. If a new request is accepted in the same cycle, it is reloaded instead.
- Read data handshake: pop the FIFO and decrement inflight.
  - rd_data = sb_rdata >> (8*offset), truncated to the size and sign- or zero-extended.
  - rd_err = 0.
- Accept and completion in the same cycle: inflight is unchanged.
- sb_rvalid or sb_bvalid while the channel's inflight = 0 is a protocol violation: ignored, no pulse, no pop.
- sb_rready = sb_bready = 1 at all times.
- req_ready is never asserted for req_size = 3 when DW = 32 unless the channel is idle; that case is the misaligned path.

## Timing
- Reset values:
  - All holds clear, inflight = 0, FIFO empty.
  - sb_arvalid = sb_wvalid = 0; addr, data and strb = 0.
  - rd_valid = wr_done = rd_err = wr_err = 0; rd_data = 0.
  - req_ready = 1.
- Accept at cycle T: sb_*valid is high from T+1 and held with stable payload until its ready.
- sb_rvalid or sb_bvalid at cycle R: rd_valid/rd_data or wr_done/wr_err at R+1 for exactly one cycle.
- Minimum read latency with sb_arready = 1 and the slave responding in the cycle after the address: accept T, address T+1, data T+2, rd_valid T+3.
- Back-to-back: one accept per cycle per channel while sb_*ready = 1 and inflight < MAX_OUT.
- Reads and writes are independent; no ordering between channels. Completions within a channel are in order.
- rst_n low mid-transaction: all state is dropped immediately and no completion pulses are generated for in-flight transactions.

## Test plan
- DW=32: load byte, addr 0x103, unsigned=0, sb_rdata 0x80FF_0000 -> sb_araddr 0x100, rd_valid at T+3, rd_data 0xFFFF_FF80.
- Store half, addr 0x202, wdata 0x1234 -> sb_waddr 0x200, sb_wstrb 4'b1100, sb_wdata 0x1234_1234; bresp=1 -> wr_done with wr_err=1.
- MAX_OUT=2, sb_arready=1, slave withholds rvalid: two reads accepted, third sees req_ready=0 and pause=1. One rvalid -> third accepted in that same cycle.
- sb_arready held 0 for 5 cycles -> sb_arvalid and sb_araddr stable throughout; second read not accepted until the handshake.
- Misaligned word load addr 0x101 while idle -> no sb_arvalid, rd_valid & rd_err next cycle. Same request with a read in flight -> req_ready=0 until that read completes.
- DW=64: dword load at 0x8 with rdata 0x0123_4567_89AB_CDEF -> passed unchanged. rst_n pulsed with 2 reads in flight -> all outputs return to reset values and no rd_valid follows.
